// File: rtl/led_pattern_gen.sv
// LED pattern generator: a prescaler paces pattern steps; the mode selects
// binary count, rotate, bounce or Gray count on a WIDTH-bit LED bus.
module led_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] leds,
    output logic             step,
    output logic             wrap
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        M_BIN  = 2'd0,
        M_ROT  = 2'd1,
        M_BNC  = 2'd2,
        M_GRAY = 2'd3
    } mode_t;

    mode_t            mode_in;
    mode_t            mode_q;
    logic [PW-1:0]    pre;
    logic [PW-1:0]    pre_n;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_n;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] leds_n;
    logic [WIDTH-1:0] rot_val;
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] gray_val;
    logic             dir;
    logic             dir_n;
    logic             step_n;
    logic             wrap_n;
    logic             tick;

    // Rotate and bounce start from a single lit LED; the counters start dark.
    function automatic logic [WIDTH-1:0] init_pattern(input mode_t m);
        if (m == M_ROT || m == M_BNC)
            return WIDTH'(1);
        return '0;
    endfunction

    assign mode_in  = mode_t'(mode);
    assign tick     = en && (pre == PRE_MAX);
    assign cnt_inc  = cnt + 1'b1;
    assign rot_val  = {leds[WIDTH-2:0], leds[WIDTH-1]};
    assign shl_val  = leds << 1;
    assign shr_val  = leds >> 1;
    assign gray_val = cnt_inc ^ (cnt_inc >> 1);

    // A mode change restarts the pattern and suppresses any tick in that cycle.
    always_comb begin
        pre_n  = pre;
        cnt_n  = cnt;
        dir_n  = dir;
        leds_n = leds;
        step_n = 1'b0;
        wrap_n = 1'b0;
        if (mode_in != mode_q) begin
            pre_n  = '0;
            cnt_n  = '0;
            dir_n  = 1'b1;
            leds_n = init_pattern(mode_in);
        end else if (tick) begin
            pre_n  = '0;
            step_n = 1'b1;
            case (mode_q)
                M_BIN: begin
                    cnt_n  = cnt_inc;
                    leds_n = cnt_inc;
                    wrap_n = (cnt_inc == '0);
                end
                M_ROT: begin
                    leds_n = rot_val;
                    wrap_n = (rot_val == WIDTH'(1));
                end
                M_BNC: begin
                    if (dir) begin
                        leds_n = shl_val;
                        if (shl_val[WIDTH-1])
                            dir_n = 1'b0;
                    end else begin
                        leds_n = shr_val;
                        if (shr_val == WIDTH'(1)) begin
                            dir_n  = 1'b1;
                            wrap_n = 1'b1;
                        end
                    end
                end
                default: begin
                    cnt_n  = cnt_inc;
                    leds_n = gray_val;
                    wrap_n = (cnt_inc == '0);
                end
            endcase
        end else if (en) begin
            pre_n = pre + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre    <= '0;
            cnt    <= '0;
            dir    <= 1'b1;
            mode_q <= mode_in;
            leds   <= init_pattern(mode_in);
            step   <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            pre    <= pre_n;
            cnt    <= cnt_n;
            dir    <= dir_n;
            mode_q <= mode_in;
            leds   <= leds_n;
            step   <= step_n;
            wrap   <= wrap_n;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: two instances (8-bit/DIV=4 and 2-bit/DIV=1) share
// stimulus and are compared against a step-index based reference model.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] leds_a;
    logic       step_a;
    logic       wrap_a;
    logic [1:0] leds_b;
    logic       step_b;
    logic       wrap_b;

    int checks = 0;
    int errors = 0;

    // Model state per instance: registered mode, steps taken, enabled cycles since last step.
    int mq[2];
    int mk[2];
    int mpc[2];
    logic ms[2];
    logic mw[2];

    led_pattern_gen #(.WIDTH(8), .DIV(4)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .leds(leds_a), .step(step_a), .wrap(wrap_a)
    );

    led_pattern_gen #(.WIDTH(2), .DIV(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .leds(leds_b), .step(step_b), .wrap(wrap_b)
    );

    always #5 clk = ~clk;

    function automatic int inst_width(input int i);
        return (i == 0) ? 8 : 2;
    endfunction

    function automatic int inst_div(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int period(input int m, input int w);
        case (m)
            0, 3: return 1 << w;
            1:    return w;
            default: return 2 * (w - 1);
        endcase
    endfunction

    // Pattern shown after k steps, derived directly from the step index.
    function automatic int pattern(input int m, input int k, input int w);
        int p;
        int b;
        case (m)
            0: return k % (1 << w);
            1: return 1 << (k % w);
            2: begin
                p = k % period(2, w);
                return (p < w) ? (1 << p) : (1 << (period(2, w) - p));
            end
            default: begin
                b = k % (1 << w);
                return b ^ (b >> 1);
            end
        endcase
    endfunction

    task automatic modelEdge();
        for (int i = 0; i < 2; i++) begin
            ms[i] = 1'b0;
            mw[i] = 1'b0;
            if (rst || int'(mode) != mq[i]) begin
                mq[i]  = int'(mode);
                mk[i]  = 0;
                mpc[i] = 0;
            end else if (en) begin
                if (mpc[i] == inst_div(i) - 1) begin
                    mk[i]  = mk[i] + 1;
                    mpc[i] = 0;
                    ms[i]  = 1'b1;
                    mw[i]  = (mk[i] % period(mq[i], inst_width(i))) == 0;
                end else begin
                    mpc[i] = mpc[i] + 1;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s got %0h expected %0h (step index %0d)", tag, got, exp, mk[0]);
        end
    endtask

    task automatic checkOutput();
        check("leds_a", 32'(leds_a), 32'(pattern(mq[0], mk[0], 8)));
        check("step_a", 32'(step_a), 32'(ms[0]));
        check("wrap_a", 32'(wrap_a), 32'(mw[0]));
        check("leds_b", 32'(leds_b), 32'(pattern(mq[1], mk[1], 2)));
        check("step_b", 32'(step_b), 32'(ms[1]));
        check("wrap_b", 32'(wrap_b), 32'(mw[1]));
    endtask

    // Inputs change 1 ns after an edge; outputs are checked at that same point.
    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m);
        rst  = r;
        en   = e;
        mode = m;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    initial begin
        #1;
        // Reset with binary mode, then a full binary wrap.
        applyStimulus(1'b1, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 2'd0);
        for (int n = 0; n < 256 * 4 + 8; n++)
            applyStimulus(1'b0, 1'b1, 2'd0);

        // Rotate, bounce and Gray sweeps.
        for (int n = 0; n < 4 * 18; n++)
            applyStimulus(1'b0, 1'b1, 2'd1);
        for (int n = 0; n < 4 * 30; n++)
            applyStimulus(1'b0, 1'b1, 2'd2);
        for (int n = 0; n < 4 * 20; n++)
            applyStimulus(1'b0, 1'b1, 2'd3);

        // Enable hold at pre=2 in binary mode.
        applyStimulus(1'b1, 1'b0, 2'd0);
        for (int n = 0; n < 40 && !(mk[0] == 2 && mpc[0] == 2); n++)
            applyStimulus(1'b0, 1'b1, 2'd0);
        for (int n = 0; n < 10; n++)
            applyStimulus(1'b0, 1'b0, 2'd0);
        for (int n = 0; n < 12; n++)
            applyStimulus(1'b0, 1'b1, 2'd0);

        // Mode change colliding with a tick while leds=0x05.
        applyStimulus(1'b1, 1'b0, 2'd0);
        for (int n = 0; n < 60 && !(mk[0] == 5 && mpc[0] == 3); n++)
            applyStimulus(1'b0, 1'b1, 2'd0);
        check("leds_before_modechg", 32'(leds_a), 32'h05);
        applyStimulus(1'b0, 1'b1, 2'd1);
        for (int n = 0; n < 12; n++)
            applyStimulus(1'b0, 1'b1, 2'd1);

        // Reset mid-bounce at 0x40 while climbing; afterwards the bounce climbs again.
        applyStimulus(1'b0, 1'b1, 2'd2);
        for (int n = 0; n < 60 && mk[0] != 6; n++)
            applyStimulus(1'b0, 1'b1, 2'd2);
        check("leds_before_rst", 32'(leds_a), 32'h40);
        applyStimulus(1'b1, 1'b1, 2'd2);
        for (int n = 0; n < 4 * 16; n++)
            applyStimulus(1'b0, 1'b1, 2'd2);

        // Randomized enable, occasional mode switches and resets.
        for (int n = 0; n < 3000; n++) begin
            logic       r;
            logic       e;
            logic [1:0] m;
            r = ($urandom_range(0, 99) < 2);
            e = ($urandom_range(0, 9) < 8);
            m = mode;
            if ($urandom_range(0, 39) == 0)
                m = 2'($urandom_range(0, 3));
            applyStimulus(r, e, m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
